chunked_subtractor: RTL and testbench

//   Multi-cycle N-bit subtractor. Computes diff = a - b - bin one W-bit chunk per clock,
//   LSB chunk first, with a start/done handshake. Produces borrow-out, signed overflow
//   and zero flags. Successor to the combinational NSubtractor: narrow chunk width trades

---
 rtl/chunked_subtractor.sv | 128 ++++++++++++
 tb/tb_chunked_subtractor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_subtractor.sv
// Multi-cycle N-bit subtractor: diff = a - b - bin, one W-bit chunk per clock.
// LSB chunk first; start/done handshake; borrow, signed overflow and zero flags.
module chunked_subtractor #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         v,
    output logic         z
);

    localparam int C  = N / W;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam logic [CW-1:0] LAST = CW'(C - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          brw_q, brw_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          bout_q, bout_d;
    logic          v_q, v_d;
    logic          z_q, z_d;
    logic          done_q, done_d;
    logic [W:0]    sub_w;

    // Operands shift right each cycle so the active chunk is always at bit 0;
    // the result fills from the top so it is aligned after the last chunk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;
        done_d  = 1'b0;
        sub_w   = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]}
                - {{W{1'b0}}, brw_q};
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> W;
                b_d   = b_q >> W;
                res_d = res_q >> W;
                res_d[N-W +: W] = sub_w[W-1:0];
                brw_d = sub_w[W];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // a_q/b_q now hold the top chunk, so bit W-1 is the sign
                    state_d = IDLE;
                    cnt_d   = cnt_q;
                    diff_d  = res_d;
                    bout_d  = sub_w[W];
                    z_d     = (res_d == '0);
                    v_d     = (a_q[W-1] != b_q[W-1])
                           && (res_d[N-1] != a_q[W-1]);
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign v    = v_q;
    assign z    = z_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Directed bench for chunked_subtractor at W=8, W=32 and W=1.
// Expected values are hand-computed constants.
module tb_chunked_subtractor;

    logic        clk;
    logic        rst;
    logic        start_w [3];
    logic [31:0] a_in, b_in;
    logic        bin_in;
    logic        busy_w [3];
    logic        done_w [3];
    logic [31:0] diff_w [3];
    logic        bout_w [3];
    logic        v_w    [3];
    logic        z_w    [3];

    int checks;
    int errors;
    int lat_exp [3] = '{4, 1, 32};

    chunked_subtractor #(.N(32), .W(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_w[0]),
        .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy_w[0]), .done(done_w[0]), .diff(diff_w[0]),
        .bout(bout_w[0]), .v(v_w[0]), .z(z_w[0])
    );

    chunked_subtractor #(.N(32), .W(32)) u_w32 (
        .clk(clk), .rst(rst), .start(start_w[1]),
        .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy_w[1]), .done(done_w[1]), .diff(diff_w[1]),
        .bout(bout_w[1]), .v(v_w[1]), .z(z_w[1])
    );

    chunked_subtractor #(.N(32), .W(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_w[2]),
        .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy_w[2]), .done(done_w[2]), .diff(diff_w[2]),
        .bout(bout_w[2]), .v(v_w[2]), .z(z_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic op(input int u, input logic [31:0] av,
                      input logic [31:0] bv, input logic bi,
                      input logic [31:0] ed, input logic eb,
                      input logic ev, input logic ez);
        int    lat;
        bit    seen;
        string t;
        t = $sformatf("u%0d %h-%h-%0d", u, av, bv, bi);
        @(negedge clk);
        a_in = av;
        b_in = bv;
        bin_in = bi;
        start_w[u] = 1'b1;
        @(posedge clk);
        #1;
        start_w[u] = 1'b0;
        a_in = ~av;
        b_in = ~bv;
        bin_in = ~bi;
        chk({t, " busy"}, 64'(busy_w[u]), 64'd1);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            seen = done_w[u];
        end
        chk({t, " lat"}, 64'(lat), 64'(lat_exp[u]));
        chk({t, " diff"}, 64'(diff_w[u]), 64'(ed));
        chk({t, " bout"}, 64'(bout_w[u]), 64'(eb));
        chk({t, " v"}, 64'(v_w[u]), 64'(ev));
        chk({t, " z"}, 64'(z_w[u]), 64'(ez));
        chk({t, " idle"}, 64'(busy_w[u]), 64'd0);
        @(posedge clk);
        #1;
        chk({t, " done_fall"}, 64'(done_w[u]), 64'd0);
        chk({t, " hold"}, 64'(diff_w[u]), 64'(ed));
    endtask

    logic [31:0] va [6] = '{32'd10, 32'd15, 32'h100,
                            32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] vb [6] = '{32'd5, 32'd15, 32'd1,
                            32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0};
    logic        vi [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vd [6] = '{32'd5, 32'd0, 32'hFF,
                            32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic        vbo[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vz [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        int ndone;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_in = '0;
        b_in = '0;
        bin_in = 1'b0;
        for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst busy u%0d", u), 64'(busy_w[u]), 64'd0);
            chk($sformatf("rst done u%0d", u), 64'(done_w[u]), 64'd0);
            chk($sformatf("rst out u%0d", u),
                {29'd0, diff_w[u], bout_w[u], v_w[u], z_w[u]}, 64'd0);
        end
        #20;
        @(negedge clk);
        rst = 1'b0;

        for (int u = 0; u < 3; u++)
            for (int k = 0; k < 6; k++)
                op(u, va[k], vb[k], vi[k], vd[k], vbo[k], vv[k], vz[k]);

        // start while busy is ignored; start in done cycle is accepted
        @(negedge clk);
        a_in = 32'd10;
        b_in = 32'd5;
        bin_in = 1'b1;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        @(posedge clk);
        #1;
        start_w[0] = 1'b1;
        a_in = 32'd100;
        b_in = 32'd1;
        bin_in = 1'b0;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        chk("b2b busy_ign", 64'(busy_w[0]), 64'd1);
        @(posedge clk);
        #1;
        chk("b2b early_done", 64'(done_w[0]), 64'd0);
        @(posedge clk);
        #1;
        chk("b2b done1", 64'(done_w[0]), 64'd1);
        chk("b2b diff1", 64'(diff_w[0]), 64'd4);
        start_w[0] = 1'b1;
        a_in = 32'd20;
        b_in = 32'd3;
        bin_in = 1'b0;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        chk("b2b done_fall", 64'(done_w[0]), 64'd0);
        chk("b2b busy2", 64'(busy_w[0]), 64'd1);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done_w[0]) ndone++;
        end
        chk("b2b no_early", 64'(ndone), 64'd0);
        chk("b2b diff_held", 64'(diff_w[0]), 64'd4);
        @(posedge clk);
        #1;
        chk("b2b done2", 64'(done_w[0]), 64'd1);
        chk("b2b diff2", 64'(diff_w[0]), 64'd17);

        // reset mid-operation aborts immediately
        @(negedge clk);
        a_in = 32'd10;
        b_in = 32'd5;
        bin_in = 1'b0;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst busy", 64'(busy_w[0]), 64'd0);
        chk("mid_rst done", 64'(done_w[0]), 64'd0);
        chk("mid_rst diff", 64'(diff_w[0]), 64'd0);
        chk("mid_rst w1 diff", 64'(diff_w[2]), 64'd0);
        chk("mid_rst w1 bout", 64'(bout_w[2]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done_w[0]) ndone++;
        end
        chk("mid_rst no_done", 64'(ndone), 64'd0);
        chk("mid_rst idle", 64'(busy_w[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
